// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, access encoding and lane helpers for the data-memory controller
package dmem_pkg;

    localparam int DMEM_ADDR_W = 7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_RESP
    } state_t;

    // Encoding value equals the position of the matching flag in the controller's flag vector.
    typedef enum logic [2:0] {
        ACC_LB,
        ACC_LH,
        ACC_LBU,
        ACC_LHU,
        ACC_LW,
        ACC_SB,
        ACC_SH,
        ACC_SW
    } acc_t;

    function automatic logic acc_is_store(input acc_t a);
        return a inside {ACC_SB, ACC_SH, ACC_SW};
    endfunction

    function automatic logic acc_aligned(input acc_t a, input logic [1:0] off);
        case (a)
            ACC_LH, ACC_LHU, ACC_SH: return !off[0];
            ACC_LW, ACC_SW:          return off == 2'b00;
            default:                 return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input acc_t a);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (a)
            ACC_LB:  return {{24{b[7]}}, b};
            ACC_LBU: return {24'h0, b};
            ACC_LH:  return {{16{h[15]}}, h};
            ACC_LHU: return {16'h0, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] data,
                                               input logic [1:0] off, input acc_t a);
        logic [31:0] res;
        res = old;
        case (a)
            ACC_SB:  res[{off, 3'b000} +: 8] = data[7:0];
            ACC_SH:  res[{off[1], 4'b0000} +: 16] = data[15:0];
            default: res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port word RAM with synchronous read and per-word write enable
module dmem_ram #(
    parameter int WORD_W    = 5,
    parameter bit INIT_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              we,
    input  logic [WORD_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int DEPTH = 1 << WORD_W;

    if (INIT_ZERO) begin : g_zero
        logic [31:0] mem [DEPTH] = '{default: 32'h0};

        always_ff @(posedge clk) begin
            if (we) mem[addr] <= wdata;
            rdata <= mem[addr];
        end
    end else begin : g_plain
        logic [31:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (we) mem[addr] <= wdata;
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - CPU data-memory responder: validates, reads/merges/writes RAM, returns loads
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = DMEM_ADDR_W,
    parameter bit INIT_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dm_ena,
    input  logic              dm_r,
    input  logic              dm_w,
    input  logic              sb_flag,
    input  logic              sh_flag,
    input  logic              sw_flag,
    input  logic              lb_flag,
    input  logic              lh_flag,
    input  logic              lbu_flag,
    input  logic              lhu_flag,
    input  logic              lw_flag,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_data_in,
    output logic [31:0]       dm_data_out,
    output logic              dm_ready,
    output logic              dm_err
);

    localparam int WORD_W = ADDR_W - 2;

    state_t            state, state_next;
    acc_t              acc, acc_q;
    logic [7:0]        flags;
    logic              req_ok;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic              ram_we;
    logic [WORD_W-1:0] ram_addr;
    logic [31:0]       ram_wdata, ram_rdata;

    assign flags = {sw_flag, sh_flag, sb_flag, lw_flag, lhu_flag, lbu_flag, lh_flag, lb_flag};

    always_comb begin
        acc = ACC_LB;
        for (int i = 0; i < 8; i++) begin
            if (flags[i]) acc = acc_t'(3'(i));
        end
    end

    assign req_ok = (dm_r ^ dm_w) && $onehot(flags) && (acc_is_store(acc) == dm_w)
                    && acc_aligned(acc, dm_addr[1:0]);

    // Accept cycle drives the RAM from the live bus; RD drives it from the latched request.
    assign ram_addr  = (state == S_IDLE) ? dm_addr[ADDR_W-1:2] : addr_q[ADDR_W-1:2];
    assign ram_wdata = (state == S_IDLE) ? dm_data_in
                                         : lane_merge(ram_rdata, data_q, addr_q[1:0], acc_q);
    assign ram_we    = !rst && (((state == S_IDLE) && dm_ena && req_ok && (acc == ACC_SW))
                                || ((state == S_RD) && acc_is_store(acc_q)));

    dmem_ram #(
        .WORD_W    (WORD_W),
        .INIT_ZERO (INIT_ZERO)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (dm_ena) state_next = (!req_ok || acc == ACC_SW) ? S_RESP : S_RD;
            end
            S_RD:    state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && dm_ena) begin
            addr_q <= dm_addr;
            data_q <= dm_data_in;
            acc_q  <= acc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dm_ready    <= 1'b0;
            dm_err      <= 1'b0;
            dm_data_out <= 32'h0;
        end else begin
            dm_ready <= 1'b0;
            dm_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (dm_ena) begin
                        dm_ready <= !req_ok || (acc == ACC_SW);
                        dm_err   <= !req_ok;
                    end
                end
                S_RD: begin
                    dm_ready <= 1'b1;
                    if (!acc_is_store(acc_q))
                        dm_data_out <= lane_extract(ram_rdata, addr_q[1:0], acc_q);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, byte-address width (2^ADDR_W bytes, 2^(ADDR_W-2) words).
REQ-002 SHALL have parameter INIT_ZERO, default 0; when 1, the RAM is zero-initialised at elaboration.
REQ-003 SHALL have ports:
  clk  in  1  single clock, all logic on rising edge
  rst  in  1  synchronous reset, active-high
  dm_ena  in  1  request valid, held stable by CPU until dm_ready
  dm_r  in  1  read request
  dm_w  in  1  write request
  sb_flag, sh_flag, sw_flag  in  1 each  store size select
  lb_flag, lh_flag, lbu_flag, lhu_flag, lw_flag  in  1 each  load size/sign select
  dm_addr  in  ADDR_W  byte address, already offset-adjusted
  dm_data_in  in  32  store data, right-justified for sb/sh
  dm_data_out  out  32  load result, sign/zero-extended
  dm_ready  out  1  one-cycle completion pulse
  dm_err  out  1  valid with dm_ready; request rejected
REQ-004 Clock is clk; reset is rst, synchronous, active-high.

Function
REQ-005 SHALL be a responder FSM with states IDLE, RD, RESP.
REQ-006 In IDLE, when dm_ena=1, SHALL latch addr, data and type (accept cycle T).
REQ-007 Valid request SHALL have exactly one of dm_r/dm_w high and exactly one flag high, of the matching direction; any other combination is an error.
REQ-008 Alignment SHALL be: lh/lhu/sh need addr[0]=0; lw/sw need addr[1:0]=0; violation is an error.
REQ-009 Error: no RAM write; IDLE->RESP; dm_ready=dm_err=1 at T+1; dm_data_out unchanged.
REQ-010 sw: full-word RAM write at edge ending T; IDLE->RESP; dm_ready at T+1.
REQ-011 sb/sh: RAM read issued at T; in RD (T+1) the addressed lane(s) SHALL be merged and written; dm_ready at T+2.
REQ-012 Loads: RAM read issued at T; in RD the lane SHALL be extracted and registered into dm_data_out; dm_ready at T+2 with data valid.
REQ-013 Byte order SHALL be little-endian: byte k (addr[1:0]=k) occupies bits 8k+7:8k; halfword at addr[1]=h occupies bits 16h+15:16h.
REQ-014 lb/lh SHALL sign-extend; lbu/lhu SHALL zero-extend to 32 bits.
REQ-015 RESP SHALL last exactly one cycle, then IDLE; a request SHALL be accepted no earlier than the cycle after dm_ready.
REQ-016 dm_data_out SHALL hold its last load value until the next successful load.
REQ-017 Request inputs sampled only at T; changes during RD/RESP SHALL be ignored.
REQ-018 Word index SHALL be addr[ADDR_W-1:2]; no wrap or bounds check beyond ADDR_W.
REQ-019 dm_ena=0 in IDLE SHALL leave state, RAM and outputs unchanged.

Reset
REQ-020 rst=1 SHALL force state IDLE, dm_ready=0, dm_err=0, dm_data_out=0 at next edge.
REQ-021 rst asserted in RD SHALL abort: a pending sb/sh merge SHALL NOT be written; no dm_ready issued.
REQ-022 RAM contents SHALL NOT be affected by rst.
REQ-023 rst SHALL take priority over any request in the same cycle.

Structure
REQ-024 Shared package dmem_pkg SHALL hold the state enum, access-type encoding (B, H, W x signed/unsigned x r/w), the default ADDR_W, and lane-extract/merge functions.
REQ-025 One sub-module dmem_ram SHALL be used: single-port, word-wide, synchronous-read, per-word write enable, depth 2^(ADDR_W-2).
REQ-026 All outputs SHALL be registered.

Verification
REQ-027 sw 0xDEADBEEF @0x04 then lw @0x04 -> dm_ready at T+1 then T+2; dm_data_out=0xDEADBEEF, dm_err=0.
REQ-028 After REQ-027, sb 0x7F @0x05 then lb @0x05 -> word=0xDEAD7FEF; lb returns 0x0000007F; lbu @0x07 returns 0x000000DE; lb @0x07 returns 0xFFFFFFDE.
REQ-029 sh 0x8001 @0x06 then lh @0x06 -> 0xFFFF8001; lhu -> 0x00008001; word @0x04 = 0x80017FEF.
REQ-030 lw @0x02, sh @0x03, dm_r=dm_w=1, and lb+lh both set -> each dm_ready=dm_err=1 at T+1; RAM and dm_data_out unchanged.
REQ-031 sb 0x55 @0x08 with rst pulsed at T+1 (RD) -> no dm_ready; word @0x08 unchanged; all outputs 0.
REQ-032 Back-to-back: sw then lw issued the cycle after each dm_ready, random addresses over 0x00-0x7C -> scoreboard match, no lost or duplicate dm_ready.
